count2_monitor: RTL
===================

# count2_monitor

Downstream checker for the 4-bit preset/clear sequence counter. The counter steps through 12 legal codes: 8, 10, 11, 13, 14, 15, 0, 1, 2, 4, 5, 7, then back to 8. This block samples the counter's Q bus on every clock, maps each legal code to its ordinal position 0..11, counts completed laps, and flags illegal codes or out-of-sequence transitions. It sits directly on the counter's Q outputs and shares the counter's clock, giving the lab bench a self-checking readout instead of waveform inspection.

## Interface

Parameters:
- LAP_W, default 8: width of the lap counter.
- ALLOW_HOLD, default 1: 1 means q unchanged between samples is legal; 0 means a repeated code is a sequence error.

Ports:
- clk  input  1  clock; all sampling on posedge.
- CLR  input  1  reset; asynchronous, active-low.
- q  input  4  counter state code, sampled each posedge.
- clr_err  input  1  synchronous error acknowledge; returns FSM to SYNC.
- valid  output  1  high while in TRACK; idx is meaningful.
- idx  output  4  ordinal of last sampled code, 0..11.
- wrap  output  1  one-cycle pulse when sequence goes from code 7 to code 8.
- laps  output  LAP_W  completed-lap count; rolls over at all-ones.
- illegal  output  1  one-cycle pulse when sampled code is 3, 6, 9 or 12.
- err  output  1  sticky sequence fault; high while in FAULT.
- exp_code  output  4  expected successor code captured at fault.
- got_code  output  4  offending code captured at fault.

## Operation

- Code to ordinal map: 8→0, 10→1, 11→2, 13→3, 14→4, 15→5, 0→6, 1→7, 2→8, 4→9, 5→10, 7→11.
- Codes 3, 6, 9 and 12 are illegal.
- Successor of ordinal k is ordinal (k+1) mod 12.
- Internal register prev (4 bits) holds the last accepted code.

FSM states: SYNC, TRACK, FAULT. Reset state is SYNC.

SYNC:
- Legal q: prev←q, idx←map(q), go to TRACK. No wrap pulse on entry.
- Illegal q: illegal pulses and the FSM stays in SYNC.

TRACK:
- q == succ(prev): prev←q, idx←map(q).
  - If prev==7 and q==8: wrap pulses and laps←laps+1 (modulo 2^LAP_W).
- q == prev and ALLOW_HOLD=1: no change to any output.
- Any other q, including illegal codes, or a hold with ALLOW_HOLD=0:
  - exp_code←succ(prev), got_code←q, err←1, valid←0, go to FAULT.
  - illegal also pulses if q is illegal.

FAULT:
- Ignores q; all outputs hold.
- clr_err=1: err←0, go to SYNC. laps, exp_code and got_code keep their values.

Priority and width rules:
- clr_err is sampled only in FAULT and is ignored in SYNC and TRACK.
- Arithmetic on laps is unsigned, LAP_W bits, and wraps silently.

## Timing

- All outputs are registered.
- A sample taken at posedge n is reflected on the outputs after edge n, with 1-cycle latency.
- wrap and illegal are high for exactly one clk cycle per event.
- Asynchronous CLR low forces immediately, mid-operation included:
  - state=SYNC, prev=0, idx=0, valid=0, wrap=0, laps=0, illegal=0, err=0, exp_code=0, got_code=0.
- CLR deasserting: the first posedge after release samples q as in SYNC.
- The counter and monitor share clk, so q changes just after each edge and is stable at the next edge.

## Test plan

- Reset: hold CLR=0 with q=8 and clocks running → all outputs 0, valid=0. Pull CLR low mid-TRACK → outputs clear the same cycle without waiting for clk.
- Clean run: release CLR, drive the legal sequence from 8 for 25 samples → valid=1 from cycle 1, idx steps 0..11 twice then 0, two wrap pulses, laps=2, err=0, illegal never high.
- Illegal in SYNC: q=12, then 13 → illegal pulses once and valid stays 0; on 13, valid=1 and idx=3.
- Skip fault: TRACK with q=10, then 13 → err=1, valid=0, exp_code=11, got_code=13. Following q changes leave all outputs unchanged. clr_err=1 for one cycle → err=0, back in SYNC; next q=14 → idx=4.
- Hold: ALLOW_HOLD=1, q=5,5,5,7 → idx 10,10,10,11 with no error. ALLOW_HOLD=0, q=5,5 → err=1, exp_code=7, got_code=5.
- Lap rollover: LAP_W=2, run 4 full laps → laps goes 1,2,3,0 and wrap pulses 4 times.

Source files
------------

// File: rtl/count2_monitor.sv
//------------------------------------------------------------------------------
// count2_monitor : sequence checker for the 12-code preset/clear counter
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module count2_monitor #(
   parameter int LAP_W      = 8,
   parameter int ALLOW_HOLD = 1
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic [3:0]       q,
   input  logic             clr_err,
   output logic             valid,
   output logic [3:0]       idx,
   output logic             wrap,
   output logic [LAP_W-1:0] laps,
   output logic             illegal,
   output logic             err,
   output logic [3:0]       exp_code,
   output logic [3:0]       got_code
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [3:0]       prev_q, prev_d;
   logic [3:0]       idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [LAP_W-1:0] laps_q, laps_d;
   logic             illegal_q, illegal_d;
   logic             err_q, err_d;
   logic [3:0]       exp_code_q, exp_code_d;
   logic [3:0]       got_code_q, got_code_d;

   logic             q_legal;
   logic [3:0]       succ_code;

   function automatic logic is_legal(input logic [3:0] code);
      return !(code == 4'd3 || code == 4'd6 || code == 4'd9 || code == 4'd12);
   endfunction

   function automatic logic [3:0] to_ord(input logic [3:0] code);
      case (code)
         4'd8:    return 4'd0;
         4'd10:   return 4'd1;
         4'd11:   return 4'd2;
         4'd13:   return 4'd3;
         4'd14:   return 4'd4;
         4'd15:   return 4'd5;
         4'd0:    return 4'd6;
         4'd1:    return 4'd7;
         4'd2:    return 4'd8;
         4'd4:    return 4'd9;
         4'd5:    return 4'd10;
         4'd7:    return 4'd11;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] to_code(input logic [3:0] ord);
      case (ord)
         4'd0:    return 4'd8;
         4'd1:    return 4'd10;
         4'd2:    return 4'd11;
         4'd3:    return 4'd13;
         4'd4:    return 4'd14;
         4'd5:    return 4'd15;
         4'd6:    return 4'd0;
         4'd7:    return 4'd1;
         4'd8:    return 4'd2;
         4'd9:    return 4'd4;
         4'd10:   return 4'd5;
         4'd11:   return 4'd7;
         default: return 4'd8;
      endcase
   endfunction

   always_comb begin
      q_legal   = is_legal(q);
      succ_code = (to_ord(prev_q) == 4'd11) ? to_code(4'd0) : to_code(to_ord(prev_q) + 4'd1);
   end

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      wrap_d     = 1'b0;
      laps_d     = laps_q;
      illegal_d  = 1'b0;
      err_d      = err_q;
      exp_code_d = exp_code_q;
      got_code_d = got_code_q;

      case (state_q)
         SYNC: begin
            if (q_legal) begin
               prev_d  = q;
               idx_d   = to_ord(q);
               valid_d = 1'b1;
               state_d = TRACK;
            end else begin
               illegal_d = 1'b1;
            end
         end
         TRACK: begin
            if (q == succ_code) begin
               prev_d = q;
               idx_d  = to_ord(q);
               // 7 -> 8 is the only transition that closes a lap
               if (q == 4'd8) begin
                  wrap_d = 1'b1;
                  laps_d = laps_q + LAP_ONE;
               end
            end else if (q == prev_q && ALLOW_HOLD != 0) begin
               state_d = TRACK;
            end else begin
               exp_code_d = succ_code;
               got_code_d = q;
               err_d      = 1'b1;
               valid_d    = 1'b0;
               illegal_d  = !q_legal;
               state_d    = FAULT;
            end
         end
         FAULT: begin
            if (clr_err) begin
               err_d   = 1'b0;
               state_d = SYNC;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state_q    <= SYNC;
         prev_q     <= 4'd0;
         idx_q      <= 4'd0;
         valid_q    <= 1'b0;
         wrap_q     <= 1'b0;
         laps_q     <= '0;
         illegal_q  <= 1'b0;
         err_q      <= 1'b0;
         exp_code_q <= 4'd0;
         got_code_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         wrap_q     <= wrap_d;
         laps_q     <= laps_d;
         illegal_q  <= illegal_d;
         err_q      <= err_d;
         exp_code_q <= exp_code_d;
         got_code_q <= got_code_d;
      end
   end

   assign valid    = valid_q;
   assign idx      = idx_q;
   assign wrap     = wrap_q;
   assign laps     = laps_q;
   assign illegal  = illegal_q;
   assign err      = err_q;
   assign exp_code = exp_code_q;
   assign got_code = got_code_q;

endmodule

`default_nettype wire
